// File: rtl/ysyx_22040127_mem_pkg.sv
// Shared encodings and default widths for the IF/LS memory arbiter slice.
package ysyx_22040127_mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam int MEM_ADDR_W = 64;
  localparam int MEM_DATA_W = 64;
  localparam int MEM_MASK_W = 8;
  localparam int CNT_W      = 16;

endpackage

// File: rtl/ysyx_22040127_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time is chosen.
module ysyx_22040127_rr_arb2
  import ysyx_22040127_mem_pkg::*;
(
  input  logic       valid_if,
  input  logic       valid_ls,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // grant[0] = IF, grant[1] = LS
  always_comb begin
    grant = 2'b00;
    if (valid_if && valid_ls) begin
      if (last_grant == OWN_IF) begin
        grant = 2'b10;
      end else begin
        grant = 2'b01;
      end
    end else if (valid_ls) begin
      grant = 2'b10;
    end else if (valid_if) begin
      grant = 2'b01;
    end else begin
      grant = 2'b00;
    end
  end

endmodule

// File: rtl/ysyx_22040127_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time,
// with round-robin arbitration and a watchdog that aborts a hung memory access.
module ysyx_22040127_mem_arbiter
  import ysyx_22040127_mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int MASK_W      = MEM_MASK_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic              ls_req_wen,
  input  logic [DATA_W-1:0] ls_req_wdata,
  input  logic [MASK_W-1:0] ls_req_wmask,
  output logic              ls_resp_valid,
  output logic [DATA_W-1:0] ls_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              timeout_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_err_q, timeout_err_d;

  logic [1:0] grant_s;
  logic       busy_s;
  logic       resp_hit_s;
  logic       timeout_s;
  logic       deliver_s;
  logic       grant_any_s;

  ysyx_22040127_rr_arb2 u_arb (
    .valid_if   (if_req_valid),
    .valid_ls   (ls_req_valid),
    .last_grant (last_grant_q),
    .grant      (grant_s)
  );

  // A real response in the deadline cycle takes precedence over the watchdog.
  always_comb begin
    busy_s      = (state_q == ST_REQ) || (state_q == ST_WAIT);
    resp_hit_s  = (state_q == ST_WAIT) && mem_resp_valid;
    timeout_s   = busy_s && (cnt_q == TIMEOUT_VAL) && !resp_hit_s;
    deliver_s   = !rst && (resp_hit_s || timeout_s);
    grant_any_s = !rst && (state_q == ST_IDLE) && (grant_s != 2'b00);
  end

  // Handshake, request and response outputs.
  always_comb begin
    if_req_ready  = grant_any_s && grant_s[0];
    ls_req_ready  = grant_any_s && grant_s[1];
    mem_req_valid = !rst && (state_q == ST_REQ) && !timeout_s;
    mem_req_addr  = addr_q;
    mem_req_wen   = wen_q;
    mem_req_wdata = wdata_q;
    mem_req_wmask = wmask_q;
    if_resp_valid = deliver_s && (owner_q == OWN_IF);
    ls_resp_valid = deliver_s && (owner_q == OWN_LS);
    if_resp_data  = {DATA_W{1'b0}};
    ls_resp_data  = {DATA_W{1'b0}};
    if (if_resp_valid && resp_hit_s) begin
      if_resp_data = mem_resp_data;
    end else begin
      if_resp_data = {DATA_W{1'b0}};
    end
    if (ls_resp_valid && resp_hit_s && !wen_q) begin
      ls_resp_data = mem_resp_data;
    end else begin
      ls_resp_data = {DATA_W{1'b0}};
    end
    timeout_err = timeout_err_q;
  end

  // Next-state logic for the transaction FSM, latched request and watchdog.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any_s) begin
          owner_d      = grant_s[1] ? OWN_LS : OWN_IF;
          last_grant_d = grant_s[1] ? OWN_LS : OWN_IF;
          addr_d       = grant_s[1] ? ls_req_addr : if_req_addr;
          wen_d        = grant_s[1] && ls_req_wen;
          wdata_d      = grant_s[1] ? ls_req_wdata : {DATA_W{1'b0}};
          wmask_d      = grant_s[1] ? ls_req_wmask : {MASK_W{1'b0}};
          cnt_d        = {CNT_W{1'b0}};
          state_d      = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ, ST_WAIT: begin
        if (cnt_q == TIMEOUT_VAL) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
        if (resp_hit_s) begin
          state_d = ST_IDLE;
        end else if (timeout_s) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end else if ((state_q == ST_REQ) && mem_req_ready) begin
          state_d = ST_WAIT;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_IF;
      last_grant_q  <= OWN_IF;
      addr_q        <= {ADDR_W{1'b0}};
      wen_q         <= 1'b0;
      wdata_q       <= {DATA_W{1'b0}};
      wmask_q       <= {MASK_W{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      addr_q        <= addr_d;
      wen_q         <= wen_d;
      wdata_q       <= wdata_d;
      wmask_q       <= wmask_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule
